// File: rtl/ccd_line_ctrl.sv
// CCD line sequencer: SH / dummy / active pixel timing with an AXI4-Stream pixel output.
// Define CCD_TEST_PATTERN_EN to replace captured samples with a (pixel + row) ramp.
module ccd_line_ctrl #(
    parameter int DATA_WIDTH  = 12,
    parameter int OUT_WIDTH   = 8,
    parameter int EFFECT_COLS = 2048,
    parameter int PRE_DUMMY   = 32,
    parameter int POST_DUMMY  = 8,
    parameter int SH_WIDTH    = 16
) (
    input  logic                  pxl_clk,
    input  logic                  rst,
    input  logic                  trigger_mode,
    input  logic                  ext_trigger,
    input  logic [24:0]           line_period,
    input  logic [10:0]           rows,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic                  sh,
    output logic                  phase_en,
    output logic                  overflow,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready
);

    localparam int MAX_A   = (SH_WIDTH > PRE_DUMMY) ? SH_WIDTH : PRE_DUMMY;
    localparam int MAX_B   = (EFFECT_COLS > POST_DUMMY) ? EFFECT_COLS : POST_DUMMY;
    localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_DUR + 1);

    localparam logic [CNT_W-1:0] SH_LAST   = CNT_W'(SH_WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_DUMMY - 1);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(EFFECT_COLS - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_DUMMY - 1);
    localparam logic [24:0] MIN_PERIOD =
        25'(SH_WIDTH + PRE_DUMMY + EFFECT_COLS + POST_DUMMY + 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SH, ST_PRE, ST_ACTIVE, ST_POST, ST_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [24:0]      period_cnt;
    logic [10:0]      row;
    logic             ext_q;

`ifdef CCD_TEST_PATTERN_EN
    function automatic logic [OUT_WIDTH-1:0] capture_data(input logic [CNT_W-1:0] pixel,
                                                          input logic [10:0] row_idx);
        logic [31:0] sum;
        sum = 32'(pixel) + 32'(row_idx);
        return sum[OUT_WIDTH-1:0];
    endfunction
`else
    function automatic logic [OUT_WIDTH-1:0] capture_data(input logic [DATA_WIDTH-1:0] sample);
        return sample[DATA_WIDTH-1 -: OUT_WIDTH];
    endfunction
`endif

    logic [24:0] period_clamped;
    logic [24:0] period_reload;
    logic [10:0] rows_last;
    logic        line_trig;

    assign period_clamped = (line_period < MIN_PERIOD) ? MIN_PERIOD : line_period;
    assign period_reload  = period_clamped - 25'd1;
    assign rows_last      = (rows == 11'd0) ? 11'd0 : rows - 11'd1;
    assign line_trig      = trigger_mode ? (ext_trigger & ~ext_q) : (period_cnt == 25'd0);

    // Stage p0: beat formed during each ACTIVE cycle
    logic                 vld_p0;
    logic [OUT_WIDTH-1:0] data_p0;
    logic                 last_p0;
    logic                 user_p0;

    assign vld_p0  = (state == ST_ACTIVE);
    assign last_p0 = (cnt == COL_LAST);
    assign user_p0 = (cnt == '0) && (row == 11'd0);
`ifdef CCD_TEST_PATTERN_EN
    assign data_p0 = capture_data(cnt, row);
`else
    assign data_p0 = capture_data(adc_data);
`endif

    always_ff @(posedge pxl_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            period_cnt <= '0;
            row        <= '0;
            ext_q      <= 1'b0;
            sh         <= 1'b0;
            phase_en   <= 1'b0;
        end else begin
            ext_q      <= ext_trigger;
            period_cnt <= (period_cnt == 25'd0) ? period_reload : period_cnt - 25'd1;
            case (state)
                ST_IDLE: begin
                    if (line_trig) begin
                        state <= ST_SH;
                        sh    <= 1'b1;
                        cnt   <= '0;
                    end
                end
                ST_SH: begin
                    if (cnt == SH_LAST) begin
                        state    <= ST_PRE;
                        sh       <= 1'b0;
                        phase_en <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_PRE: begin
                    if (cnt == PRE_LAST) begin
                        state <= ST_ACTIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (cnt == COL_LAST) begin
                        state <= ST_POST;
                        cnt   <= '0;
                        row   <= (row >= rows_last) ? 11'd0 : row + 11'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_POST: begin
                    if (cnt == POST_LAST) begin
                        state    <= ST_WAIT;
                        phase_en <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: state <= ST_IDLE;
                default: begin
                    state    <= ST_IDLE;
                    sh       <= 1'b0;
                    phase_en <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

    // Stage p1: one-deep output register; a beat that cannot land only leaves its flags behind
    always_ff @(posedge pxl_clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tdata  <= '0;
            overflow      <= 1'b0;
        end else if (vld_p0) begin
            if (!m_axis_tvalid || m_axis_tready) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= data_p0;
                m_axis_tlast  <= last_p0;
                m_axis_tuser  <= user_p0;
            end else begin
                overflow     <= 1'b1;
                m_axis_tlast <= m_axis_tlast | last_p0;
                m_axis_tuser <= m_axis_tuser | user_p0;
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end
    end

endmodule
